// File: rtl/term_line_ctrl.sv
// Line-editing terminal controller: buffers printable input with echo, handles
// backspace, and on CR parses a "Whh" command that loads reg_o.
//
// state   | meaning
// IDLE    | waiting for a received byte (pending register or direct from rx)
// DECODE  | classify consumed byte, update line buffer, build echo sequence
// SEND    | strobe tx_start_o with the current sequence byte
// WAIT_TX | wait for tx_done_i, then advance the sequence
// PARSE   | interpret the completed line and build the response
module term_line_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  output logic [7:0] reg_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {IDLE, DECODE, SEND, WAIT_TX, PARSE} state_t;

  state_t                  state_q, state_d;
  logic                    pend_full_q, pend_full_d;
  logic [7:0]              pend_data_q, pend_data_d;
  logic [7:0]              cur_q, cur_d;
  logic [LW-1:0]           len_q, len_d;
  logic [DEPTH-1:0][7:0]   buf_q, buf_d;
  logic [3:0][7:0]         seq_q, seq_d;
  logic [2:0]              seq_len_q, seq_len_d;
  logic [1:0]              seq_idx_q, seq_idx_d;
  logic                    to_parse_q, to_parse_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [7:0]              reg_q, reg_d;
  logic                    overrun_q, overrun_d;

  // {valid, nibble}; only uppercase hex digits are accepted
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

  logic       consume, bypass;
  logic [4:0] hex_hi, hex_lo;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    cur_d       = cur_q;
    len_d       = len_q;
    buf_d       = buf_q;
    seq_d       = seq_q;
    seq_len_d   = seq_len_q;
    seq_idx_d   = seq_idx_q;
    to_parse_d  = to_parse_q;
    tx_data_d   = tx_data_q;
    reg_d       = reg_q;
    overrun_d   = overrun_q;
    consume     = 1'b0;
    bypass      = 1'b0;
    hex_hi      = hex_dec(buf_q[1]);
    hex_lo      = hex_dec(buf_q[2]);

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          cur_d   = pend_data_q;
          consume = 1'b1;
          state_d = DECODE;
        end else if (rx_done_i) begin
          // empty pending register: take the byte straight through
          cur_d   = rx_data_i;
          bypass  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        to_parse_d = 1'b0;
        seq_idx_d  = 2'd0;
        state_d    = SEND;
        if (cur_q >= 8'h20 && cur_q <= 8'h7E) begin
          seq_len_d = 3'd1;
          if (len_q < DEPTH_L) begin
            buf_d[len_q[LW-2:0]] = cur_q;
            len_d    = len_q + 1'b1;
            seq_d[0] = cur_q;
          end else begin
            seq_d[0] = 8'h07;
          end
        end else if (cur_q == 8'h08) begin
          if (len_q != '0) begin
            len_d     = len_q - 1'b1;
            seq_d[0]  = 8'h08;
            seq_d[1]  = 8'h20;
            seq_d[2]  = 8'h08;
            seq_len_d = 3'd3;
          end else begin
            state_d = IDLE;
          end
        end else if (cur_q == 8'h0D) begin
          seq_d[0]   = 8'h0D;
          seq_d[1]   = 8'h0A;
          seq_len_d  = 3'd2;
          to_parse_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
        if (state_d == SEND) tx_data_d = seq_d[0];
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done_i) begin
          if (({1'b0, seq_idx_q} + 3'd1) < seq_len_q) begin
            seq_idx_d = seq_idx_q + 2'd1;
            tx_data_d = seq_q[seq_idx_q + 2'd1];
            state_d   = SEND;
          end else begin
            state_d = to_parse_q ? PARSE : IDLE;
          end
        end
      end
      PARSE: begin
        len_d      = '0;
        to_parse_d = 1'b0;
        state_d    = IDLE;
        if (len_q != '0) begin
          if (len_q == LW'(3) && buf_q[0] == 8'h57 && hex_hi[4] && hex_lo[4]) begin
            reg_d    = {hex_hi[3:0], hex_lo[3:0]};
            seq_d[0] = 8'h4F;
            seq_d[1] = 8'h4B;
          end else begin
            seq_d[0] = 8'h45;
            seq_d[1] = 8'h52;
          end
          seq_d[2]  = 8'h0D;
          seq_d[3]  = 8'h0A;
          seq_len_d = 3'd4;
          seq_idx_d = 2'd0;
          tx_data_d = seq_d[0];
          state_d   = SEND;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) pend_full_d = 1'b0;
    if (rx_done_i && !bypass) begin
      if (!pend_full_q || consume) begin
        pend_full_d = 1'b1;
        pend_data_d = rx_data_i;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      pend_data_q <= 8'h00;
      cur_q       <= 8'h00;
      len_q       <= '0;
      buf_q       <= '0;
      seq_q       <= '0;
      seq_len_q   <= 3'd0;
      seq_idx_q   <= 2'd0;
      to_parse_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      reg_q       <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      cur_q       <= cur_d;
      len_q       <= len_d;
      buf_q       <= buf_d;
      seq_q       <= seq_d;
      seq_len_q   <= seq_len_d;
      seq_idx_q   <= seq_idx_d;
      to_parse_q  <= to_parse_d;
      tx_data_q   <= tx_data_d;
      reg_q       <= reg_d;
      overrun_q   <= overrun_d;
    end
  end

  assign tx_start_o = (state_q == SEND);
  assign tx_data_o  = tx_data_q;
  assign reg_o      = reg_q;
  assign busy_o     = (state_q != IDLE);
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_term_line_ctrl.sv
// Directed bench for term_line_ctrl: a transmitter model answers each tx_start_o
// with tx_done_i four cycles later and checks every byte against a scoreboard.
module tb_term_line_ctrl;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_done_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       tx_done_i = 1'b0;
  logic [7:0] reg_o;
  logic       busy_o;
  logic       overrun_o;

  term_line_ctrl #(.DEPTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
    .reg_o(reg_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = no timing check, 1 = one cycle after last tx_done, 2 = two cycles after rx_done
  typedef struct {logic [7:0] b; int kind;} exp_t;
  exp_t sb[$];

  int n_checks = 0, n_err = 0;
  int rx_cyc = -100, done_cyc = -100, n_starts = 0, cnt = 0;
  logic [7:0] held = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // transmitter model and scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done_i) tx_done_i = 1'b0;
      if (!rst_ni) begin
        cnt = 0;
      end else if (tx_start_o) begin
        n_starts++;
        n_checks++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_tx_start: observed=%0h expected=none", tx_data_o);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tx_data", {24'h0, tx_data_o}, {24'h0, e.b});
          if (e.kind == 1) check("tx_gap_after_done", cyc - done_cyc, 1);
          if (e.kind == 2) check("tx_lat_after_rx", cyc - rx_cyc, 2);
        end
        held = tx_data_o;
        cnt = 4;
      end else if (cnt > 0) begin
        check("tx_data_hold", {24'h0, tx_data_o}, {24'h0, held});
        cnt--;
        if (cnt == 0) begin
          tx_done_i = 1'b1;
          done_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b, input int kind);
    exp_t e;
    e.b = b; e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data_i = b; rx_done_i = 1'b1; rx_cyc = cyc;
    @(negedge clk);
    rx_done_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy_o || sb.size() != 0 || cnt != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n < 300, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start_o, 0);
    check({tag, "_tx_data"}, tx_data_o, 0);
    check({tag, "_reg"}, reg_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    rst_ni = 1'b1;
  endtask

  task automatic echo(input logic [7:0] b, input logic [7:0] exp_b, input string tag);
    push(exp_b, 2);
    send(b);
    wait_idle(tag);
  endtask

  task automatic cr_with_resp(input logic [7:0] r0, input logic [7:0] r1, input string tag);
    push(8'h0D, 2); push(8'h0A, 1);
    push(r0, 0); push(r1, 1); push(8'h0D, 1); push(8'h0A, 1);
    send(8'h0D);
    wait_idle(tag);
  endtask

  initial begin
    int n;
    int s0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    // write command with valid hex
    echo(8'h57, 8'h57, "w_echo");
    echo(8'h33, 8'h33, "3_echo");
    echo(8'h43, 8'h43, "C_echo");
    cr_with_resp(8'h4F, 8'h4B, "ok_resp");
    check("reg_after_W3C", reg_o, 8'h3C);
    check("tx_data_idle_hold", tx_data_o, 8'h0A);

    // lowercase hex rejected
    do_reset("reset2");
    echo(8'h57, 8'h57, "w2_echo");
    echo(8'h33, 8'h33, "32_echo");
    echo(8'h63, 8'h63, "c_echo");
    cr_with_resp(8'h45, 8'h52, "er_lower");
    check("reg_after_W3c", reg_o, 8'h00);

    // buffer full: 17th printable byte gets BEL
    for (int i = 0; i < 17; i++)
      echo(8'h61 + 8'(i), (i < 16) ? 8'h61 + 8'(i) : 8'h07, "fill_echo");
    cr_with_resp(8'h45, 8'h52, "er_full");

    // backspace at empty line, then "A" + backspace
    s0 = n_starts;
    send(8'h08);
    wait_idle("bs_empty");
    check("bs_empty_no_tx", n_starts, s0);
    echo(8'h41, 8'h41, "A_echo");
    push(8'h08, 2); push(8'h20, 1); push(8'h08, 1);
    send(8'h08);
    wait_idle("bs_echo");
    push(8'h0D, 2); push(8'h0A, 1);
    send(8'h0D);
    wait_idle("cr_empty");
    check("bs_starts", n_starts, s0 + 6);

    // overrun: three bytes back to back while waiting on the transmitter
    check("overrun_before", overrun_o, 0);
    push(8'h58, 2);
    send(8'h58);
    n = 0;
    while (!tx_start_o && n < 20) begin @(negedge clk); n++; end
    check("x_start_timeout", n < 20, 1);
    push(8'h59, 0);
    @(negedge clk); rx_data_i = 8'h59; rx_done_i = 1'b1;
    @(negedge clk); rx_data_i = 8'h5A;
    @(negedge clk); rx_data_i = 8'h51;
    @(negedge clk); rx_done_i = 1'b0;
    wait_idle("overrun");
    check("overrun_set", overrun_o, 1);
    cr_with_resp(8'h45, 8'h52, "er_overrun");
    check("overrun_sticky", overrun_o, 1);

    // reset during the "OK" response
    do_reset("reset3");
    echo(8'h57, 8'h57, "w3_echo");
    echo(8'h34, 8'h34, "4_echo");
    echo(8'h31, 8'h31, "1_echo");
    push(8'h0D, 2); push(8'h0A, 1); push(8'h4F, 0);
    send(8'h0D);
    n = 0;
    while (!(tx_start_o && tx_data_o == 8'h4F) && n < 100) begin @(negedge clk); n++; end
    check("o_start_timeout", n < 100, 1);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    check("mid_reset_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    push(8'h0D, 2); push(8'h0A, 1);
    send(8'h0D);
    wait_idle("cr_after_reset");
    check("final_sb_empty", sb.size(), 0);
    check("final_reg", reg_o, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/term_line_ctrl.md
TERM_LINE_CTRL -- requirements
Module: term_line_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, 16, line-buffer capacity in characters (power of two, 4..64).
REQ-002 SHALL have port: clk_i  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: rx_done_i  input  1  one-cycle strobe, received byte valid on rx_data_i.
REQ-005 SHALL have port: rx_data_i  input  8  received byte.
REQ-006 SHALL have port: tx_start_o  output  1  one-cycle strobe starting transmission of tx_data_o.
REQ-007 SHALL have port: tx_data_o  output  8  byte to transmit, held stable from tx_start_o until tx_done_i.
REQ-008 SHALL have port: tx_done_i  input  1  one-cycle strobe, transmitter finished current byte.
REQ-009 SHALL have port: reg_o  output  8  register written by "W" command.
REQ-010 SHALL have port: busy_o  output  1  high whenever controller is not in IDLE.
REQ-011 SHALL have port: overrun_o  output  1  sticky flag, received byte lost.

Function
REQ-012 SHALL contain a 1-byte pending register (data + full flag); rx_done_i writes it in any state.
REQ-013 SHALL set overrun_o and discard the new byte when rx_done_i arrives while pending is full and not being consumed that cycle; same-cycle consume and write SHALL keep the new byte.
REQ-014 SHALL implement states IDLE, DECODE, SEND, WAIT_TX, PARSE.
REQ-015 IDLE: pending full -> consume into DECODE next cycle; else remain.
REQ-016 DECODE SHALL select an output sequence and buffer action from the consumed byte, then go to SEND.
REQ-017 Printable byte (0x20..0x7E), length < DEPTH: store at buf[length], length+1, echo the byte.
REQ-018 Printable byte, length = DEPTH: not stored, echo 0x07 (BEL).
REQ-019 Backspace 0x08, length > 0: length-1, echo 0x08,0x20,0x08; length = 0: no echo, return to IDLE.
REQ-020 CR 0x0D: echo 0x0D,0x0A, then go to PARSE after the last echo completes; LF 0x0A and all other bytes SHALL be ignored (return to IDLE).
REQ-021 SEND SHALL pulse tx_start_o for one cycle with the current sequence byte and go to WAIT_TX.
REQ-022 WAIT_TX SHALL wait for tx_done_i; next byte -> SEND next cycle; sequence end -> IDLE or PARSE per REQ-020.
REQ-023 tx_start_o SHALL assert exactly 2 cycles after rx_done_i when controller idle and pending empty.
REQ-024 Consecutive tx bytes: tx_start_o SHALL assert exactly 1 cycle after the preceding tx_done_i.
REQ-025 PARSE: length = 0 -> IDLE, no response; length = 3, buf[0]="W" (0x57), buf[1..2] hex digits 0-9/A-F uppercase -> reg_o <= {hex(buf[1]),hex(buf[2])}, send "OK",0x0D,0x0A; otherwise send "ER",0x0D,0x0A, reg_o unchanged.
REQ-026 PARSE SHALL clear length to 0 in all cases; lowercase hex SHALL be an error.
REQ-027 tx_done_i outside WAIT_TX SHALL be ignored.
REQ-028 tx_data_o SHALL hold its last value when idle.

Reset
REQ-029 rst_ni low at a clock edge SHALL force state IDLE, length 0, pending empty, reg_o 0x00, overrun_o 0, tx_start_o 0, tx_data_o 0x00, busy_o 0, including mid-sequence; a transmission in flight is abandoned.
REQ-030 overrun_o SHALL clear only on reset.

Verification
REQ-031 Bench: send "W","3","C",CR with tx_done_i 4 cycles after each start -> echoes W,3,C,0D,0A then O,K,0D,0A; reg_o = 0x3C after response.
REQ-032 Bench: send "W","3","c",CR -> response E,R,0D,0A; reg_o unchanged 0x00.
REQ-033 Bench: DEPTH+1 printable bytes -> last echo 0x07; CR then yields E,R,0D,0A.
REQ-034 Bench: backspace at length 0 -> no tx_start_o; "A",0x08 -> echoes 41,08,20,08, length 0.
REQ-035 Bench: three rx_done_i on consecutive cycles while WAIT_TX -> first kept in pending, overrun_o = 1, later echo of first byte only.
REQ-036 Bench: rst_ni low during response "OK" -> next cycle all outputs at reset values, subsequent CR gives only 0D,0A.
